// File: rtl/reg_write_arbiter_pkg.sv
// Shared state encoding and default sizing for the register write arbiter.
package reg_arb_pkg;
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_COMMIT = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ = 3;
    localparam int DEF_NREG = 4;
    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 2;
endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side write bus plus readback port of the register write arbiter.
interface reg_write_arbiter_if #(
    parameter int NREQ = reg_arb_pkg::DEF_NREQ,
    parameter int DW   = reg_arb_pkg::DEF_DW,
    parameter int AW   = reg_arb_pkg::DEF_AW
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    clr;
    logic [NREQ*AW-1:0] wr_addr;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               busy;
    logic [AW-1:0]      rd_addr;
    logic [DW-1:0]      rd_data;

    modport master (
        output req, clr, wr_addr, wr_data, rd_addr,
        input  gnt, ack, busy, rd_data
    );

    modport slave (
        input  req, clr, wr_addr, wr_data, rd_addr,
        output gnt, ack, busy, rd_data
    );
endinterface

// File: rtl/reg_write_arbiter_bank.sv
// Register bank: NREG entries with active-low enable and per-entry synchronous clear.
module reg_bank
    import reg_arb_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW
) (
    input  logic                     clk,
    input  logic                     aReset,
    input  logic [NREG-1:0]          i_en_b,
    input  logic [NREG-1:0]          i_clr,
    input  logic [DW-1:0]            i_wr_data,
    output logic [NREG-1:0][DW-1:0]  o_q
);
    logic [NREG-1:0][DW-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!aReset) begin
            r_q <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (i_clr[i]) begin
                    r_q[i] <= '0;
                end else if (!i_en_b[i]) begin
                    r_q[i] <= i_wr_data;
                end
            end
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin register write arbiter. IDLE: sample req, pick winner | GRANT: write bank entry
// | COMMIT: ack winner, advance round-robin pointer.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int NREG = DEF_NREG,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic               clk,
    input  logic               aReset,
    reg_write_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    arb_state_t              r_state;
    logic [IW-1:0]           r_ptr;
    logic [IW-1:0]           r_win;
    logic [AW-1:0]           r_addr;
    logic [DW-1:0]           r_data;
    logic                    r_clr;
    logic [NREQ-1:0]         r_gnt;
    logic [NREQ-1:0]         r_ack;
    logic                    r_busy;

    logic                    w_found;
    logic [IW-1:0]           w_win;
    logic [AW-1:0]           w_sel_addr;
    logic [DW-1:0]           w_sel_data;
    logic                    w_sel_clr;
    logic [NREG-1:0]         w_en_b;
    logic [NREG-1:0]         w_clr;
    logic [NREG-1:0][DW-1:0] w_bank;

    // First requesting index at or after r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_clr  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && bus.req[j] && ((int'(r_ptr) + k) % NREQ) == j) begin
                    w_found    = 1'b1;
                    w_win      = IW'(j);
                    w_sel_addr = bus.wr_addr[j*AW +: AW];
                    w_sel_data = bus.wr_data[j*DW +: DW];
                    w_sel_clr  = bus.clr[j];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!aReset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_clr   <= 1'b0;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_win   <= w_win;
                        r_addr  <= w_sel_addr;
                        r_data  <= w_sel_data;
                        r_clr   <= w_sel_clr;
                        r_gnt   <= ONE << w_win;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    r_gnt   <= '0;
                    r_ack   <= r_gnt;
                    r_state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Out-of-range addresses match no entry, so nothing is enabled.
    always_comb begin
        w_en_b = '1;
        w_clr  = '0;
        for (int i = 0; i < NREG; i++) begin
            if (r_state == ST_GRANT && r_addr == AW'(i)) begin
                w_en_b[i] = r_clr;
                w_clr[i]  = r_clr;
            end
        end
    end

    reg_bank #(
        .NREG (NREG),
        .DW   (DW)
    ) u_bank (
        .clk       (clk),
        .aReset    (aReset),
        .i_en_b    (w_en_b),
        .i_clr     (w_clr),
        .i_wr_data (r_data),
        .o_q       (w_bank)
    );

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                bus.rd_data = w_bank[i];
            end
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.ack  = r_ack;
    assign bus.busy = r_busy;
endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter NREQ, 3, number of write requesters (2..8) SHALL be supported.
REQ-002 Parameter NREG, 4, number of register entries in the bank SHALL be supported.
REQ-003 Parameter DW, 8, data width of each entry SHALL be supported.
REQ-004 Parameter AW, 2, entry address width, SHALL satisfy 2**AW >= NREG.
REQ-005 Port clk, input, 1, SHALL be the clock; all state SHALL update on its rising edge.
REQ-006 Port aReset, input, 1, SHALL be the reset: synchronous, active-low.
REQ-007 Port req, input, NREQ, SHALL carry per-requester write requests, held high until ack.
REQ-008 Port clr, input, NREQ, SHALL mark a request as a clear (write zero) rather than a data write.
REQ-009 Port wr_addr, input, NREQ*AW, SHALL carry the target entry; requester i uses bits [i*AW +: AW].
REQ-010 Port wr_data, input, NREQ*DW, SHALL carry write data; requester i uses bits [i*DW +: DW].
REQ-011 Port gnt, output, NREQ, SHALL be a one-hot grant, high only in GRANT.
REQ-012 Port ack, output, NREQ, SHALL be a one-hot, one-cycle completion pulse, high only in COMMIT.
REQ-013 Port busy, output, 1, SHALL be high in any state other than IDLE.
REQ-014 Port rd_addr, input, AW, SHALL select the entry for readback.
REQ-015 Port rd_data, output, DW, SHALL show the entry at rd_addr combinationally; out-of-range rd_addr SHALL read 0.

Function
REQ-016 The FSM SHALL have three states: IDLE, GRANT, COMMIT.
REQ-017 IDLE: if any req bit is high, the winner SHALL be chosen round-robin starting at pointer ptr; its index, addr, data and clr SHALL be registered, and the next state SHALL be GRANT.
REQ-018 IDLE with req == 0 SHALL remain in IDLE.
REQ-019 GRANT: the bank entry at the registered addr SHALL be enabled for exactly one cycle; it SHALL load 0 if clr was set, otherwise the registered data; the next state SHALL be COMMIT.
REQ-020 COMMIT: ack[winner] SHALL pulse; ptr SHALL become (winner+1) mod NREQ; the next state SHALL be IDLE.
REQ-021 Latency from req sampled high in IDLE to bank update SHALL be 2 edges; ack SHALL follow one cycle after the update; sustained throughput SHALL be one write per 3 cycles.
REQ-022 Requester inputs SHALL be sampled only in IDLE; changes to req, addr, data or clr during GRANT or COMMIT SHALL NOT affect the write in flight.
REQ-023 A requester that drops req after being sampled SHALL still receive its write and ack.
REQ-024 With simultaneous requests, ptr SHALL give the first-priority requester; ptr wrap-around from NREQ-1 to 0 SHALL be correct.
REQ-025 A write to an out-of-range addr (>= NREG) SHALL alter no entry, but SHALL complete the handshake with an ack.
REQ-026 Entries not addressed SHALL hold their value, with their enables inactive.
REQ-027 A readback of the entry being written SHALL return the old value during GRANT and the new value from COMMIT onward.

Reset
REQ-028 aReset low at a clk edge SHALL force: state IDLE, ptr 0, gnt 0, ack 0, busy 0, all bank entries 0.
REQ-029 Reset asserted in GRANT or COMMIT SHALL abort the operation, with no ack issued and no pending write retained.
REQ-030 Reset SHALL take priority over any write in the same cycle.

Structure
REQ-031 The state encoding (IDLE, GRANT, COMMIT) and the default parameter constants SHALL live in a shared package, reg_arb_pkg.
REQ-032 The bank SHALL be one sub-module, reg_bank: NREG entries of DW-bit flops with synchronous active-low reset, active-low per-entry enable and per-entry synchronous clear.
REQ-033 The round-robin select SHALL be combinational logic inside reg_write_arbiter; no other sub-modules SHALL be used.

Verification
REQ-034 Single write: req=001, addr0=2, data0=0xA5 -> gnt=001 one cycle later; entry2=0xA5 after the GRANT edge; ack=001 in COMMIT; busy high for 2 cycles.
REQ-035 Contention: req=111 held, ptr=0 -> grant order 0,1,2,0, each ack 3 cycles apart; ptr wraps 2->0.
REQ-036 Clear: entry1=0x3C, then requester 2 with clr=1, addr=1, data=0xFF -> entry1=0x00.
REQ-037 Reset mid-op: aReset low in GRANT for one edge -> no ack, bank all 0, state IDLE, ptr=0.
REQ-038 Input change in flight: data changed 0x11->0x22 during GRANT -> entry holds 0x11.
REQ-039 Out-of-range: NREG=3, addr=3 -> no entry changes; ack still pulses; rd_addr=3 reads 0.
